// File: rtl/upsample_2d_pkg.sv
// Shared types for the nearest-neighbour 2D upsampler.
// Also hosts the counter-width helper used by the top.
package upsample_pkg;

    typedef enum logic [1:0] {
        LIVE,
        PRIME,
        REPLAY
    } up_state_t;

    localparam int PIX_W = 8;

    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/upsample_2d_if.sv
// Pixel stream bundle: upstream input side plus downstream output side.
// slave = upsampler view, master = source/sink view.
interface upsample_2d_if;
    import upsample_pkg::*;

    logic [PIX_W-1:0] in_data;
    logic             in_valid;
    logic             in_ready;
    logic [PIX_W-1:0] out_data;
    logic             out_valid;
    logic             out_ready;
    logic             out_last;

    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, out_data, out_valid, out_last
    );

    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, out_data, out_valid, out_last
    );

endinterface

// File: rtl/upsample_2d_line_buffer.sv
// Simple dual-port line store: one write port, one registered read port.
// Read data only changes when a read is issued.
module line_buffer_ram #(
    parameter int DEPTH = 120,
    parameter int AW    = 7
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [7:0]    wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [7:0]    rdata
);

    logic [7:0] mem [DEPTH];
    logic [7:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata_q <= mem[raddr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/upsample_2d.sv
// Nearest-neighbour 2D upsampler: first copy of a line passes straight
// through, the remaining vertical copies replay from the line buffer.
module upsample_2d
    import upsample_pkg::*;
#(
    parameter int UP_FACTOR = 2,
    parameter int IN_WIDTH  = 120,
    parameter int IN_HEIGHT = 240
) (
    input logic          clk,
    input logic          reset,
    upsample_2d_if.slave io
);

    localparam int XW = cnt_w(UP_FACTOR);
    localparam int CW = cnt_w(IN_WIDTH);
    localparam int RW = cnt_w(IN_HEIGHT);

    up_state_t state_q, state_d;
    logic [XW-1:0] xr_q, xr_d;
    logic [XW-1:0] yr_q, yr_d;
    logic [CW-1:0] col_q, col_d;
    logic [RW-1:0] row_q, row_d;

    logic          xr_last, col_last, yr_last, row_last;
    logic          xfer, we, re;
    logic [CW-1:0] raddr;
    logic [7:0]    rd_data;
    logic [7:0]    out_data;
    logic          out_valid, in_ready;

    assign xr_last  = (xr_q == XW'(UP_FACTOR - 1));
    assign yr_last  = (yr_q == XW'(UP_FACTOR - 1));
    assign col_last = (col_q == CW'(IN_WIDTH - 1));
    assign row_last = (row_q == RW'(IN_HEIGHT - 1));
    assign xfer     = out_valid && io.out_ready;

    always_comb begin
        state_d   = state_q;
        xr_d      = xr_q;
        yr_d      = yr_q;
        col_d     = col_q;
        row_d     = row_q;
        out_data  = io.in_data;
        out_valid = 1'b0;
        in_ready  = 1'b0;
        we        = 1'b0;
        re        = 1'b0;
        raddr     = '0;
        unique case (state_q)
            LIVE: begin
                out_valid = io.in_valid && !reset;
                in_ready  = io.out_ready && xr_last && !reset;
                if (xfer) begin
                    xr_d = xr_last ? '0 : xr_q + 1'b1;
                end
                // A pixel is consumed only on its final horizontal copy
                if (xfer && xr_last) begin
                    we    = 1'b1;
                    col_d = col_last ? '0 : col_q + 1'b1;
                    if (col_last) begin
                        if (UP_FACTOR > 1) begin
                            yr_d    = XW'(1);
                            state_d = PRIME;
                        end else begin
                            row_d = row_last ? '0 : row_q + 1'b1;
                        end
                    end
                end
            end
            PRIME: begin
                re      = 1'b1;
                state_d = REPLAY;
            end
            REPLAY: begin
                out_valid = !reset;
                out_data  = rd_data;
                if (xfer) begin
                    xr_d = xr_last ? '0 : xr_q + 1'b1;
                end
                // Prefetch the next pixel so replay runs without bubbles
                if (xfer && xr_last) begin
                    if (!col_last) begin
                        re    = 1'b1;
                        raddr = col_q + 1'b1;
                        col_d = col_q + 1'b1;
                    end else begin
                        col_d = '0;
                        if (yr_last) begin
                            yr_d    = '0;
                            row_d   = row_last ? '0 : row_q + 1'b1;
                            state_d = LIVE;
                        end else begin
                            yr_d    = yr_q + 1'b1;
                            state_d = PRIME;
                        end
                    end
                end
            end
            default: state_d = LIVE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= LIVE;
            xr_q    <= '0;
            yr_q    <= '0;
            col_q   <= '0;
            row_q   <= '0;
        end else begin
            state_q <= state_d;
            xr_q    <= xr_d;
            yr_q    <= yr_d;
            col_q   <= col_d;
            row_q   <= row_d;
        end
    end

    line_buffer_ram #(
        .DEPTH (IN_WIDTH),
        .AW    (CW)
    ) u_lbuf (
        .clk   (clk),
        .we    (we),
        .waddr (col_q),
        .wdata (io.in_data),
        .re    (re),
        .raddr (raddr),
        .rdata (rd_data)
    );

    assign io.out_data  = out_data;
    assign io.out_valid = out_valid;
    assign io.in_ready  = in_ready;
    assign io.out_last  = out_valid && row_last && yr_last
                          && col_last && xr_last;

endmodule

// File: tb/tb_upsample_2d.sv
// Self-checking bench: three upsampler configurations share one stimulus
// driver; a frame-level reference model supplies the expected pixels.
module tb_upsample_2d;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] in_data = '0;
    logic       in_valid = 1'b0;
    logic       out_ready = 1'b0;

    int errors = 0;
    int checks = 0;
    int sel = 0;

    logic [7:0] o_data;
    logic       o_valid, o_last, o_in_ready;

    logic [7:0] in_q[$];
    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    upsample_2d_if ifa ();
    upsample_2d_if ifb ();
    upsample_2d_if ifc ();

    assign ifa.in_data = in_data;
    assign ifa.in_valid = in_valid;
    assign ifa.out_ready = out_ready;
    assign ifb.in_data = in_data;
    assign ifb.in_valid = in_valid;
    assign ifb.out_ready = out_ready;
    assign ifc.in_data = in_data;
    assign ifc.in_valid = in_valid;
    assign ifc.out_ready = out_ready;

    upsample_2d #(.UP_FACTOR(2), .IN_WIDTH(4), .IN_HEIGHT(2)) u_a (
        .clk(clk), .reset(reset), .io(ifa)
    );
    upsample_2d #(.UP_FACTOR(3), .IN_WIDTH(2), .IN_HEIGHT(1)) u_b (
        .clk(clk), .reset(reset), .io(ifb)
    );
    upsample_2d #(.UP_FACTOR(1), .IN_WIDTH(4), .IN_HEIGHT(2)) u_c (
        .clk(clk), .reset(reset), .io(ifc)
    );

    always_comb begin
        case (sel)
            1: begin
                o_data = ifb.out_data; o_valid = ifb.out_valid;
                o_last = ifb.out_last; o_in_ready = ifb.in_ready;
            end
            2: begin
                o_data = ifc.out_data; o_valid = ifc.out_valid;
                o_last = ifc.out_last; o_in_ready = ifc.in_ready;
            end
            default: begin
                o_data = ifa.out_data; o_valid = ifa.out_valid;
                o_last = ifa.out_last; o_in_ready = ifa.in_ready;
            end
        endcase
    end

    // Reference: every input pixel repeated uf times across, every line uf times down
    task automatic build_expected(input int uf, input int w, input int h);
        exp_q.delete();
        for (int r = 0; r < h; r++)
            for (int y = 0; y < uf; y++)
                for (int c = 0; c < w; c++)
                    for (int x = 0; x < uf; x++)
                        exp_q.push_back(in_q[r*w + c]);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        reset = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic run_stream(input int uf, input int w, input int h,
                              input bit rnd_ready, input bit rnd_gap,
                              input int stop_at);
        int idx = 0;
        int ptr = 0;
        int bubbles = 0;
        int cyc = 0;
        int n;
        bit hold = 0;
        bit live;
        logic [7:0] prev = '0;
        build_expected(uf, w, h);
        n = exp_q.size();
        while (idx < n && (stop_at < 0 || idx < stop_at) && cyc < 4000) begin
            @(negedge clk);
            cyc++;
            out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            if (ptr < in_q.size()) begin
                in_data = in_q[ptr];
                in_valid = hold ? 1'b1 :
                           (rnd_gap ? ($urandom_range(0, 2) != 0) : 1'b1);
            end else begin
                in_valid = 1'b0;
            end
            #1;
            live = ((idx / (w * uf)) % uf) == 0;
            checks++;
            if (o_in_ready && !out_ready) begin
                errors++;
                $display("FAIL in_ready_stalled: in_ready=%0b out_ready=%0b", o_in_ready, out_ready);
            end
            if (hold) begin
                checks++;
                if (o_valid !== 1'b1 || o_data !== prev) begin
                    errors++;
                    $display("FAIL stall_hold: valid=%0b data=%0d required valid=1 data=%0d", o_valid, o_data, prev);
                end
            end
            if (uf == 1) begin
                checks++;
                if (o_in_ready !== out_ready) begin
                    errors++;
                    $display("FAIL pass_ready: in_ready=%0b required %0b", o_in_ready, out_ready);
                end
            end
            checks++;
            if (live) begin
                if (o_valid !== in_valid) begin
                    errors++;
                    $display("FAIL live_valid: out_valid=%0b required %0b", o_valid, in_valid);
                end
            end else begin
                if (o_in_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL replay_in_ready: in_ready=%0b required 0", o_in_ready);
                end
                if (!o_valid) bubbles++;
            end
            if (o_valid && out_ready) begin
                checks++;
                if (o_data !== exp_q[idx] || o_last !== (idx == n - 1)) begin
                    errors++;
                    $display("FAIL out[%0d]: data=%0d last=%0b required data=%0d last=%0b", idx, o_data, o_last, exp_q[idx], (idx == n - 1));
                end
                idx++;
            end
            if (in_valid && o_in_ready) ptr++;
            hold = o_valid && !out_ready;
            prev = o_data;
        end
        if (stop_at < 0) begin
            checks++;
            if (idx != n) begin
                errors++;
                $display("FAIL frame_count: outputs=%0d required %0d (cycle budget)", idx, n);
            end
            checks++;
            if (bubbles != h * (uf - 1)) begin
                errors++;
                $display("FAIL bubbles: got %0d required %0d", bubbles, h * (uf - 1));
            end
            checks++;
            if (ptr != in_q.size()) begin
                errors++;
                $display("FAIL consumed: got %0d required %0d", ptr, in_q.size());
            end
            @(negedge clk);
            in_valid = 1'b0;
            out_ready = 1'b1;
            #1;
            checks++;
            if (o_valid !== 1'b0) begin
                errors++;
                $display("FAIL idle_after_frame: out_valid=%0b required 0", o_valid);
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic fill_seq(input int first, input int count);
        in_q.delete();
        for (int i = 0; i < count; i++) in_q.push_back(8'(first + i));
    endtask

    task automatic fill_rand(input int count);
        in_q.delete();
        for (int i = 0; i < count; i++) in_q.push_back(8'($urandom));
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset = 1'b1;
        in_valid = 1'b1;
        in_data = 8'hAA;
        out_ready = 1'b1;
        repeat (2) begin
            @(posedge clk);
            #1;
            for (int s = 0; s < 3; s++) begin
                sel = s;
                #0;
                checks++;
                if (o_valid !== 1'b0 || o_in_ready !== 1'b0 || o_last !== 1'b0) begin
                    errors++;
                    $display("FAIL reset[%0d]: valid=%0b in_ready=%0b last=%0b required 0,0,0", s, o_valid, o_in_ready, o_last);
                end
            end
        end
        @(negedge clk);
        reset = 1'b0;
        in_valid = 1'b0;
        sel = 0;
    endtask

    task automatic test_basic();
        pulse_reset();
        sel = 0;
        fill_seq(1, 8);
        run_stream(2, 4, 2, 1'b0, 1'b0, -1);
    endtask

    task automatic test_random_ready();
        pulse_reset();
        sel = 0;
        fill_seq(1, 8);
        run_stream(2, 4, 2, 1'b1, 1'b0, -1);
    endtask

    task automatic test_in_gaps();
        pulse_reset();
        sel = 0;
        fill_rand(8);
        run_stream(2, 4, 2, 1'b0, 1'b1, -1);
        fill_rand(8);
        run_stream(2, 4, 2, 1'b1, 1'b1, -1);
    endtask

    task automatic test_uf3();
        pulse_reset();
        sel = 1;
        in_q.delete();
        in_q.push_back(8'd5);
        in_q.push_back(8'd6);
        run_stream(3, 2, 1, 1'b0, 1'b0, -1);
        fill_rand(2);
        run_stream(3, 2, 1, 1'b1, 1'b1, -1);
    endtask

    task automatic test_mid_reset();
        pulse_reset();
        sel = 0;
        fill_seq(1, 8);
        run_stream(2, 4, 2, 1'b0, 1'b0, 10);
        test_reset();
        fill_seq(9, 8);
        run_stream(2, 4, 2, 1'b0, 1'b0, -1);
    endtask

    task automatic test_passthrough();
        pulse_reset();
        sel = 2;
        fill_seq(1, 8);
        run_stream(1, 4, 2, 1'b0, 1'b0, -1);
        fill_rand(8);
        run_stream(1, 4, 2, 1'b1, 1'b1, -1);
    endtask

    task automatic test_back_to_back();
        pulse_reset();
        sel = 0;
        for (int f = 0; f < 3; f++) begin
            fill_rand(8);
            run_stream(2, 4, 2, 1'b1, 1'b1, -1);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_random_ready();
        test_in_gaps();
        test_uf3();
        test_mid_reset();
        test_passthrough();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
